// File: rtl/f_pc_sequencer.sv
// Fetch-stage PC owner for the 5-stage MIPS pipeline.
// Chooses the next fetch address from CP0 exception entry, eret return,
// D-stage jump/branch, hazard stall and sequential fetch. It also tracks
// the exception level, and parks a redirect while instruction memory is busy.
//
// Handshake with instruction memory: F_pc is offered every cycle, and
// imem_ready=1 means the address is accepted at this rising edge. Only an
// accepted fetch advances F_pc and raises F_valid for the next cycle. A
// cycle without acceptance leaves F_pc unchanged and F_valid low, and any
// redirect chosen in that cycle is parked in pend_pc/pend_src.
module f_pc_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] ERET_OFS   = 32'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        req,
   input  logic        eret,
   input  logic [31:0] epc,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        imem_ready,
   output logic [31:0] F_pc,
   output logic        F_valid,
   output logic        F_flush_D,
   output logic        exl,
   output logic        dbg_state
);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_REQ  = 2'd1,
      SRC_ERET = 2'd2,
      SRC_BR   = 2'd3
   } src_t;

   state_t      state_q, state_d;
   src_t        pend_src_q, pend_src_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic [31:0] f_pc_d;
   logic        f_valid_d;
   logic        exl_d;
   // Set by reset and cleared by the first accepted fetch. The first fetch
   // after reset is RESET_PC itself, so the address must not step ahead by 4.
   logic        boot_q, boot_d;

   logic        req_e;
   logic [31:0] eret_pc;
   logic [31:0] seq_pc;
   src_t        run_src;
   logic [31:0] run_pc;
   src_t        wait_src;
   logic [31:0] wait_pc;

   // A request that arrives while already in the handler is dropped.
   assign req_e     = req & ~exl;
   assign eret_pc   = epc + ERET_OFS;
   assign F_flush_D = req_e | eret;
   assign dbg_state = state_q;

   // Sequential candidate: hold on stall and on the boot fetch, else PC+4.
   always_comb begin
      seq_pc = F_pc + 32'd4;
      if (stall || boot_q) begin
         seq_pc = F_pc;
      end
   end

   // RUN-state redirect arbitration: req_e > eret > unstalled branch.
   always_comb begin
      run_src = SRC_NONE;
      run_pc  = seq_pc;
      if (req_e) begin
         run_src = SRC_REQ;
         run_pc  = HANDLER_PC;
      end else if (eret) begin
         run_src = SRC_ERET;
         run_pc  = eret_pc;
      end else if (br_taken && !stall) begin
         run_src = SRC_BR;
         run_pc  = br_target;
      end
   end

   // WAIT-state overwrite rules: req_e always replaces the parked redirect,
   // and eret replaces it unless an exception entry is already parked.
   // A branch never replaces it, because D re-issues it after the flush.
   always_comb begin
      wait_src = SRC_NONE;
      wait_pc  = pend_pc_q;
      if (req_e) begin
         wait_src = SRC_REQ;
         wait_pc  = HANDLER_PC;
      end else if (eret && (pend_src_q != SRC_REQ)) begin
         wait_src = SRC_ERET;
         wait_pc  = eret_pc;
      end
   end

   // Next-state, next-PC, exl and pending-redirect update.
   always_comb begin
      state_d    = state_q;
      f_pc_d     = F_pc;
      f_valid_d  = F_valid;
      exl_d      = exl;
      pend_pc_d  = pend_pc_q;
      pend_src_d = pend_src_q;
      boot_d     = boot_q;

      case (state_q)
         ST_RUN: begin
            if (run_src == SRC_REQ) begin
               exl_d = 1'b1;
            end else if (run_src == SRC_ERET) begin
               exl_d = 1'b0;
            end

            if (imem_ready) begin
               f_pc_d    = run_pc;
               f_valid_d = 1'b1;
               boot_d    = 1'b0;
            end else if (run_src != SRC_NONE) begin
               pend_pc_d  = run_pc;
               pend_src_d = run_src;
               f_valid_d  = 1'b0;
               state_d    = ST_WAIT;
            end else begin
               f_valid_d = 1'b0;
            end
         end

         ST_WAIT: begin
            f_valid_d = 1'b0;
            if (wait_src != SRC_NONE) begin
               pend_pc_d  = wait_pc;
               pend_src_d = wait_src;
               exl_d      = (wait_src == SRC_REQ);
            end

            if (imem_ready) begin
               f_pc_d     = wait_pc;
               f_valid_d  = 1'b1;
               pend_src_d = SRC_NONE;
               boot_d     = 1'b0;
               state_d    = ST_RUN;
            end
         end

         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State and datapath registers; reset discards any parked redirect.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_RUN;
         F_pc       <= RESET_PC;
         F_valid    <= 1'b0;
         exl        <= 1'b0;
         pend_pc_q  <= 32'd0;
         pend_src_q <= SRC_NONE;
         boot_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         F_pc       <= f_pc_d;
         F_valid    <= f_valid_d;
         exl        <= exl_d;
         pend_pc_q  <= pend_pc_d;
         pend_src_q <= pend_src_d;
         boot_q     <= boot_d;
      end
   end

endmodule

// File: tb/tb_f_pc_sequencer.sv
// Directed bench for f_pc_sequencer: reset/boot, sequential fetch, branch
// with and without stall, exception entry, eret, and imem back-pressure
// with parked redirects. Expected values are hand-computed constants.
module tb_f_pc_sequencer;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        req;
   logic        eret;
   logic [31:0] epc;
   logic        br_taken;
   logic [31:0] br_target;
   logic        imem_ready;
   logic [31:0] F_pc;
   logic        F_valid;
   logic        F_flush_D;
   logic        exl;
   logic        dbg_state;

   int n_vec = 0;
   int n_err = 0;

   f_pc_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .req        (req),
      .eret       (eret),
      .epc        (epc),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .imem_ready (imem_ready),
      .F_pc       (F_pc),
      .F_valid    (F_valid),
      .F_flush_D  (F_flush_D),
      .exl        (exl),
      .dbg_state  (dbg_state)
   );

   // Clock: 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net against a hung run.
   initial begin
      #100000;
      $display("FAIL timeout: observed no finish, expected finish before 100000");
      $fatal(1, "timeout");
   end

   // Advance one rising edge and settle outputs.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset      = 1'b0;
      stall      = 1'b0;
      req        = 1'b0;
      eret       = 1'b0;
      epc        = 32'd0;
      br_taken   = 1'b0;
      br_target  = 32'd0;
      imem_ready = 1'b1;

      // Reset values.
      step(); step();
      chk("rst_pc",    F_pc, 32'h0000_3000);
      chk("rst_valid", 32'(F_valid), 32'd0);
      chk("rst_exl",   32'(exl), 32'd0);
      chk("rst_flush", 32'(F_flush_D), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);

      // Release; first edge keeps RESET_PC and raises F_valid.
      reset = 1'b1; #1;
      chk("rel_valid", 32'(F_valid), 32'd0);
      step();
      chk("boot_pc",    F_pc, 32'h0000_3000);
      chk("boot_valid", 32'(F_valid), 32'd1);
      step(); chk("seq1_pc", F_pc, 32'h0000_3004);
      step(); chk("seq2_pc", F_pc, 32'h0000_3008);
      step(); step(); chk("seq4_pc", F_pc, 32'h0000_3010);

      // Branch while stalled is ignored; unstalled it redirects.
      stall = 1'b1; br_taken = 1'b1; br_target = 32'h0000_3400;
      step();
      chk("br_stall_pc",    F_pc, 32'h0000_3010);
      chk("br_stall_valid", 32'(F_valid), 32'd1);
      stall = 1'b0;
      step(); chk("br_pc", F_pc, 32'h0000_3400);
      br_target = 32'h0000_3020;
      step(); chk("br2_pc", F_pc, 32'h0000_3020);
      br_taken = 1'b0;

      // Exception request overrides stall.
      req = 1'b1; stall = 1'b1; #1;
      chk("req_flush", 32'(F_flush_D), 32'd1);
      step();
      chk("req_pc",  F_pc, 32'h0000_4180);
      chk("req_exl", 32'(exl), 32'd1);
      // Second request while in the handler is ignored.
      stall = 1'b0; #1;
      chk("req2_flush", 32'(F_flush_D), 32'd0);
      step();
      chk("req2_pc",  F_pc, 32'h0000_4184);
      chk("req2_exl", 32'(exl), 32'd1);
      req = 1'b0;

      // eret returns to epc+4 and clears exl.
      eret = 1'b1; epc = 32'h0000_3020; #1;
      chk("eret_flush", 32'(F_flush_D), 32'd1);
      step();
      chk("eret_pc",  F_pc, 32'h0000_3024);
      chk("eret_exl", 32'(exl), 32'd0);
      // req and eret together: req wins.
      req = 1'b1;
      step();
      chk("both_pc",  F_pc, 32'h0000_4180);
      chk("both_exl", 32'(exl), 32'd1);
      req = 1'b0; epc = 32'h0000_3100;
      step();
      chk("eret2_pc",  F_pc, 32'h0000_3104);
      chk("eret2_exl", 32'(exl), 32'd0);
      eret = 1'b0;

      // imem busy 3 cycles with a branch parked in the first.
      imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h0000_3500;
      step();
      chk("w1_pc",    F_pc, 32'h0000_3104);
      chk("w1_valid", 32'(F_valid), 32'd0);
      chk("w1_state", 32'(dbg_state), 32'd1);
      br_target = 32'h0000_3bb0;
      step(); chk("w2_pc", F_pc, 32'h0000_3104);
      br_taken = 1'b0;
      step(); chk("w3_valid", 32'(F_valid), 32'd0);
      imem_ready = 1'b1;
      step();
      chk("wx_pc",    F_pc, 32'h0000_3500);
      chk("wx_valid", 32'(F_valid), 32'd1);
      chk("wx_state", 32'(dbg_state), 32'd0);

      // Same, with a request in the second busy cycle.
      imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h0000_3500;
      step();
      br_taken = 1'b0; req = 1'b1; #1;
      chk("wr_flush", 32'(F_flush_D), 32'd1);
      step();
      chk("wr_exl", 32'(exl), 32'd1);
      chk("wr_pc",  F_pc, 32'h0000_3500);
      req = 1'b0;
      step();
      imem_ready = 1'b1;
      step();
      chk("wr_exit_pc",    F_pc, 32'h0000_4180);
      chk("wr_exit_valid", 32'(F_valid), 32'd1);

      // eret replaces a parked branch.
      imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h0000_3600;
      step();
      br_taken = 1'b0; eret = 1'b1; epc = 32'h0000_3700;
      step(); chk("we_exl", 32'(exl), 32'd0);
      eret = 1'b0; imem_ready = 1'b1;
      step(); chk("we_pc", F_pc, 32'h0000_3704);

      // eret does not replace a parked exception entry.
      imem_ready = 1'b0; req = 1'b1;
      step(); chk("wq_exl", 32'(exl), 32'd1);
      req = 1'b0; eret = 1'b1; epc = 32'h0000_3800;
      step(); chk("wq_exl2", 32'(exl), 32'd1);
      eret = 1'b0; imem_ready = 1'b1;
      step(); chk("wq_pc", F_pc, 32'h0000_4180);
      eret = 1'b1; epc = 32'h0000_3ffc;
      step();
      chk("wq_ret_pc",  F_pc, 32'h0000_4000);
      chk("wq_ret_exl", 32'(exl), 32'd0);
      eret = 1'b0;

      // Reset in WAIT discards the parked handler entry.
      imem_ready = 1'b0; req = 1'b1;
      step();
      chk("rw_state", 32'(dbg_state), 32'd1);
      chk("rw_exl",   32'(exl), 32'd1);
      req = 1'b0; reset = 1'b0; #1;
      chk("rw_pc",     F_pc, 32'h0000_3000);
      chk("rw_exl0",   32'(exl), 32'd0);
      chk("rw_valid",  32'(F_valid), 32'd0);
      chk("rw_state0", 32'(dbg_state), 32'd0);
      imem_ready = 1'b1;
      step(); step();
      reset = 1'b1;
      step();
      chk("rw_boot_pc",    F_pc, 32'h0000_3000);
      chk("rw_boot_valid", 32'(F_valid), 32'd1);
      step(); chk("rw_seq_pc", F_pc, 32'h0000_3004);

      // eret target wraps around and passes misaligned bits through.
      eret = 1'b1; epc = 32'hffff_fffe;
      step(); chk("wrap_pc", F_pc, 32'h0000_0002);
      eret = 1'b0;
      step(); chk("wrap_seq_pc", F_pc, 32'h0000_0006);

      // Busy imem without a redirect: hold, stay in RUN.
      imem_ready = 1'b0;
      step();
      chk("idle_pc",    F_pc, 32'h0000_0006);
      chk("idle_valid", 32'(F_valid), 32'd0);
      chk("idle_state", 32'(dbg_state), 32'd0);
      imem_ready = 1'b1;
      step(); chk("idle_next_pc", F_pc, 32'h0000_000a);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/f_pc_sequencer.md
Name: f_pc_sequencer

Overview:
- Owns the fetch-stage PC register and sequences the next-PC selection for the 5-stage MIPS pipeline.
- Arbitrates the redirect sources: CP0 exception request, D-stage eret, D-stage jump/branch, hazard stall and sequential fetch.
- Tracks the exception level (EXL).
- Holds a pending redirect while instruction memory is not ready, so no redirect is lost.

Parameters:
- RESET_PC, 32'h0000_3000, F_pc value after reset.
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry address.
- ERET_OFS, 32'd4, offset added to epc on eret.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  F/D hazard stall from the hazard unit.
- req  in  1  exception/interrupt request from CP0.
- eret  in  1  eret decoded in D.
- epc  in  32  EPC from CP0.
- br_taken  in  1  D-stage jump/branch redirect valid.
- br_target  in  32  D-stage redirect target (jump/jr/taken branch).
- imem_ready  in  1  instruction memory accepts F_pc this cycle.
- F_pc  out  32  current fetch address.
- F_valid  out  1  F instruction valid (0 = bubble into D).
- F_flush_D  out  1  kill instruction currently in D.
- exl  out  1  1 while in handler.

Behaviour:
- Reset (reset=0, async):
  - F_pc=RESET_PC, F_valid=0, exl=0, state=RUN, pend_pc=0, pend_src=NONE.
  - F_flush_D has no reset value of its own; it follows its combinational equation.
- First rising edge after reset release: F_valid<=1, F_pc stays RESET_PC.
- Effective request: req_e = req & ~exl. req while exl=1 is ignored.
- Redirect priority, high to low: req_e -> HANDLER_PC; eret -> epc+ERET_OFS (32-bit wraparound add); br_taken & ~stall -> br_target; ~stall -> F_pc+4; stall -> hold.
- br_taken while stall=1 is ignored, because D holds and reasserts it.
- req_e and eret override stall.
- F_flush_D = req_e | eret (combinational, same cycle).
- exl: set at the edge where req_e is accepted or captured; cleared at the edge where eret is accepted or captured. Simultaneous req_e and eret: req wins, exl stays 1.
- States:
  - RUN
    - Next PC is chosen per the priority above.
    - If imem_ready=1: F_pc<=next, F_valid<=1.
    - If imem_ready=0 and a redirect is selected: pend_pc<=target, pend_src<=source, go to WAIT, F_valid<=0.
    - If imem_ready=0 with no redirect: hold F_pc, F_valid<=0.
  - WAIT
    - F_pc holds, F_valid=0.
    - A new req_e overwrites pend_pc/pend_src.
    - A new eret overwrites only if pend_src != REQ.
    - A new br_taken never overwrites.
    - If imem_ready=1: F_pc<=pend_pc (or the overwriting target in the same cycle), F_valid<=1, pend_src<=NONE, go to RUN.
- Reset asserted in WAIT: pending redirect discarded; state returns to the reset values above.
- PC is not alignment-checked; F_pc[1:0] passes through (AdEL is detected downstream).

Test Plan:
- Reset release with imem_ready=1, no events -> F_pc 0x3000 with F_valid=0, then F_valid=1; subsequent edges give 0x3004, 0x3008.
- F_pc=0x3010, br_taken=1, br_target=0x3400, stall=0 -> next F_pc=0x3400; repeat with stall=1 -> F_pc holds 0x3010.
- req=1, stall=1, F_pc=0x3020 -> F_flush_D=1 same cycle; next F_pc=0x4180, exl=1; a second req while exl=1 -> ignored.
- exl=1, eret=1, epc=0x3020 -> F_flush_D=1; next F_pc=0x3024, exl=0. Also: req and eret together -> 0x4180, exl=1.
- imem_ready=0 for 3 cycles with br_taken to 0x3500 in the first cycle -> F_pc holds and F_valid=0; on ready -> 0x3500, F_valid=1. Repeat with req in the second cycle -> 0x4180.
- Reset asserted mid-WAIT -> F_pc=0x3000, exl=0, pending discarded; after release the pending target is never fetched.
